param_register_file: RTL and testbench
======================================

PARAM_REGISTER_FILE -- requirements
Module: param_register_file

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data width of every register.
REQ-002 SHALL have parameter ADDR_W, default 5, address width; DEPTH = 2**ADDR_W registers.
REQ-003 SHALL have parameter ZERO_REG, default 1, when 1 register 0 reads as zero and ignores writes.
REQ-004 SHALL have parameter BYPASS, default 1, when 1 same-cycle write data is forwarded to read ports.
REQ-005 SHALL have port clk  in  1  single clock; all state changes on rising edge.
REQ-006 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have port wr_en  in  1  write enable (the RF_WRITE role).
REQ-008 SHALL have port wr_addr  in  ADDR_W  destination register (Rdst).
REQ-009 SHALL have port wr_data  in  WIDTH  write data (RY).
REQ-010 SHALL have ports rd_addr_a, rd_addr_b  in  ADDR_W  source addresses (Rsrc1, Rsrc2).
REQ-011 SHALL have ports rd_data_a, rd_data_b  out  WIDTH  read data (RA, RB), combinational.
REQ-012 SHALL have port rsv_en  in  1  reserve a register as pending-write (scoreboard set).
REQ-013 SHALL have port rsv_addr  in  ADDR_W  register to reserve.
REQ-014 SHALL have ports pend_a, pend_b  out  1  pending-write flag for rd_addr_a / rd_addr_b.
REQ-015 SHALL have port view_sel  in  ADDR_W  debug register select.
REQ-016 SHALL have port view_data  out  WIDTH  debug view of R[view_sel], no bypass.
REQ-017 SHALL have port init_busy  out  1  high while clear sequencer runs.

Function
REQ-018 SHALL implement a two-state FSM: CLEAR and READY.
REQ-019 SHALL, in CLEAR, write 0 to R[clr_ptr] on each rising edge and increment clr_ptr from 0.
REQ-020 SHALL move CLEAR->READY on the edge that clears R[DEPTH-1]; clearing takes exactly DEPTH edges.
REQ-021 SHALL drive init_busy = 1 in CLEAR, 0 in READY.
REQ-022 SHALL, in CLEAR, ignore wr_en and rsv_en and drive rd_data_a/b, view_data = 0, pend_a/b = 0.
REQ-023 SHALL, in READY, write wr_data to R[wr_addr] on a rising edge with wr_en = 1.
REQ-024 SHALL, with ZERO_REG = 1, return 0 for address 0 on all read ports and ignore writes and reservations to address 0.
REQ-025 SHALL, with BYPASS = 1, READY, wr_en = 1, rd_addr_x == wr_addr (not zero reg), drive rd_data_x = wr_data in the same cycle.
REQ-026 SHALL keep a DEPTH-bit pending vector: rsv_en sets pend[rsv_addr], wr_en clears pend[wr_addr], on the rising edge.
REQ-027 SHALL, on simultaneous set and clear of the same address, leave the bit set (newer reservation wins).
REQ-028 SHALL drive pend_x = pend[rd_addr_x], forced 0 when BYPASS = 1 and the REQ-025 forwarding condition holds.
REQ-029 SHALL support both read ports and view port addressing the same register simultaneously.

Reset
REQ-030 SHALL, on rst_n low, immediately enter CLEAR, set clr_ptr = 0, clear all pend bits, assert init_busy = 1.
REQ-031 SHALL, on rst_n low mid-CLEAR or mid-READY, abandon in-progress clearing and restart from clr_ptr = 0 after release.
REQ-032 SHALL perform the first clear write on the first rising edge with rst_n high.

Verification
REQ-033 SHALL cover: release rst_n with defaults -> init_busy high for 32 edges, low after 32nd; all 32 registers read 0.
REQ-034 SHALL cover: READY, write 0xDEADBEEF to R5, rd_addr_a = 5 same cycle -> rd_data_a = 0xDEADBEEF (bypass); next cycle view_sel = 5 -> 0xDEADBEEF.
REQ-035 SHALL cover: write 0x12345678 to R0 -> rd_data_a/b and view_data for address 0 remain 0.
REQ-036 SHALL cover: rsv_en to R7 -> pend_a = 1 for rd_addr_a = 7; write R7 -> pend_a 0 in write cycle and after; rsv_en and wr_en to R7 same edge -> pend stays 1.
REQ-037 SHALL cover: rst_n pulsed low at clear edge 10 -> init_busy stays high, full 32-edge clear restarts; writes during CLEAR discarded.
REQ-038 SHALL cover: WIDTH = 16, ADDR_W = 3, ZERO_REG = 0, BYPASS = 0 -> 8-edge clear, R0 writable, same-cycle read returns old value.

Source files
------------

// File: rtl/param_register_file.sv
// Parameterised register file with a power-up clear sequencer,
// write-to-read forwarding and a pending-write scoreboard.
module param_register_file #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [WIDTH-1:0]  rd_data_a,
  output logic [WIDTH-1:0]  rd_data_b,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  output logic              pend_a,
  output logic              pend_b,
  input  logic [ADDR_W-1:0] view_sel,
  output logic [WIDTH-1:0]  view_data,
  output logic              init_busy
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  typedef enum logic {
    CLEAR,
    READY
  } state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] clr_ptr_q;
  logic              init_busy_q;
  logic [DEPTH-1:0]  pend_q;
  logic [DEPTH-1:0]  pend_d;
  logic [WIDTH-1:0]  regs_q [DEPTH];

  logic ready;
  logic wr_ok;
  logic rsv_ok;
  logic zero_a;
  logic zero_b;
  logic zero_v;
  logic fwd_a;
  logic fwd_b;
  logic wr_zero;

  assign ready   = (state_q == READY);
  assign wr_zero = (ZERO_REG != 0) && (wr_addr == '0);
  assign wr_ok   = ready && wr_en && !wr_zero;
  assign rsv_ok  = ready && rsv_en &&
                   !((ZERO_REG != 0) && (rsv_addr == '0));

  assign zero_a = (ZERO_REG != 0) && (rd_addr_a == '0);
  assign zero_b = (ZERO_REG != 0) && (rd_addr_b == '0);
  assign zero_v = (ZERO_REG != 0) && (view_sel == '0);

  assign fwd_a = (BYPASS != 0) && wr_ok &&
                 (rd_addr_a == wr_addr);
  assign fwd_b = (BYPASS != 0) && wr_ok &&
                 (rd_addr_b == wr_addr);

  // Set is applied after clear so a fresh reservation wins.
  always_comb begin
    pend_d = pend_q;
    if (wr_ok) begin
      pend_d[wr_addr] = 1'b0;
    end
    if (rsv_ok) begin
      pend_d[rsv_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= CLEAR;
      clr_ptr_q   <= '0;
      init_busy_q <= 1'b1;
      pend_q      <= '0;
    end else begin
      pend_q <= pend_d;
      unique case (state_q)
        CLEAR: begin
          clr_ptr_q <= clr_ptr_q + ADDR_W'(1);
          if (clr_ptr_q == '1) begin
            state_q     <= READY;
            init_busy_q <= 1'b0;
          end
        end
        READY: begin
          state_q <= READY;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == CLEAR) begin
      regs_q[clr_ptr_q] <= '0;
    end else if (wr_ok) begin
      regs_q[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    rd_data_a = '0;
    rd_data_b = '0;
    view_data = '0;
    pend_a    = 1'b0;
    pend_b    = 1'b0;
    if (ready) begin
      if (!zero_a) begin
        rd_data_a = fwd_a ? wr_data : regs_q[rd_addr_a];
      end
      if (!zero_b) begin
        rd_data_b = fwd_b ? wr_data : regs_q[rd_addr_b];
      end
      if (!zero_v) begin
        view_data = regs_q[view_sel];
      end
      pend_a = pend_q[rd_addr_a] && !fwd_a;
      pend_b = pend_q[rd_addr_b] && !fwd_b;
    end
  end

  assign init_busy = init_busy_q;

endmodule

// File: tb/tb_param_register_file.sv
// Directed bench for param_register_file: default build plus a
// small 16-bit / 8-entry build without zero register or bypass.
module tb_param_register_file;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [4:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic [4:0]  rd_addr_a = '0;
  logic [4:0]  rd_addr_b = '0;
  logic [31:0] rd_data_a;
  logic [31:0] rd_data_b;
  logic        rsv_en = 1'b0;
  logic [4:0]  rsv_addr = '0;
  logic        pend_a;
  logic        pend_b;
  logic [4:0]  view_sel = '0;
  logic [31:0] view_data;
  logic        init_busy;

  logic        s_rst_n = 1'b0;
  logic        s_wr_en = 1'b0;
  logic [2:0]  s_wr_addr = '0;
  logic [15:0] s_wr_data = '0;
  logic [2:0]  s_rd_addr_a = '0;
  logic [2:0]  s_rd_addr_b = '0;
  logic [15:0] s_rd_data_a;
  logic [15:0] s_rd_data_b;
  logic        s_rsv_en = 1'b0;
  logic [2:0]  s_rsv_addr = '0;
  logic        s_pend_a;
  logic        s_pend_b;
  logic [2:0]  s_view_sel = '0;
  logic [15:0] s_view_data;
  logic        s_init_busy;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  param_register_file dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .rd_data_a (rd_data_a),
    .rd_data_b (rd_data_b),
    .rsv_en    (rsv_en),
    .rsv_addr  (rsv_addr),
    .pend_a    (pend_a),
    .pend_b    (pend_b),
    .view_sel  (view_sel),
    .view_data (view_data),
    .init_busy (init_busy)
  );

  param_register_file #(
    .WIDTH    (16),
    .ADDR_W   (3),
    .ZERO_REG (0),
    .BYPASS   (0)
  ) dut_s (
    .clk       (clk),
    .rst_n     (s_rst_n),
    .wr_en     (s_wr_en),
    .wr_addr   (s_wr_addr),
    .wr_data   (s_wr_data),
    .rd_addr_a (s_rd_addr_a),
    .rd_addr_b (s_rd_addr_b),
    .rd_data_a (s_rd_data_a),
    .rd_data_b (s_rd_data_b),
    .rsv_en    (s_rsv_en),
    .rsv_addr  (s_rsv_addr),
    .pend_a    (s_pend_a),
    .pend_b    (s_pend_b),
    .view_sel  (s_view_sel),
    .view_data (s_view_data),
    .init_busy (s_init_busy)
  );

  task automatic test_reset();
    int first;
    rd_addr_a = 5'd3;
    #12;
    total++;
    if (init_busy !== 1'b1) begin
      bad++;
      $display("FAIL rst_busy got=%b exp=1", init_busy);
    end
    total++;
    if (rd_data_a !== 32'h0) begin
      bad++;
      $display("FAIL rst_rd got=%h exp=0", rd_data_a);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    first = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (!init_busy && first == 0) first = n;
    end
    total++;
    if (first !== 32) begin
      bad++;
      $display("FAIL clr_edges got=%0d exp=32", first);
    end
    for (int i = 0; i < 32; i++) begin
      rd_addr_a = 5'(i);
      rd_addr_b = 5'(31 - i);
      view_sel  = 5'(i);
      #1;
      total++;
      if ((rd_data_a | rd_data_b | view_data) !== 32'h0) begin
        bad++;
        $display("FAIL clr_r%0d got=%h/%h/%h exp=0", i,
                 rd_data_a, rd_data_b, view_data);
      end
    end
  endtask

  task automatic test_bypass();
    @(posedge clk); #1;
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
    rd_addr_a = 5'd5; rd_addr_b = 5'd4; view_sel = 5'd5;
    #1;
    total++;
    if (rd_data_a !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL byp_a got=%h exp=deadbeef", rd_data_a);
    end
    total++;
    if (rd_data_b !== 32'h0) begin
      bad++;
      $display("FAIL byp_b got=%h exp=0", rd_data_b);
    end
    total++;
    if (view_data !== 32'h0) begin
      bad++;
      $display("FAIL byp_view got=%h exp=0", view_data);
    end
    @(posedge clk); #1;
    wr_en = 1'b0;
    #1;
    total++;
    if (view_data !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL wr_view got=%h exp=deadbeef", view_data);
    end
    total++;
    if (rd_data_a !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL wr_rda got=%h exp=deadbeef", rd_data_a);
    end
  endtask

  task automatic test_zero();
    @(posedge clk); #1;
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h12345678;
    rd_addr_a = 5'd0; rd_addr_b = 5'd0; view_sel = 5'd0;
    #1;
    total++;
    if (rd_data_a !== 32'h0) begin
      bad++;
      $display("FAIL z_byp got=%h exp=0", rd_data_a);
    end
    @(posedge clk); #1;
    wr_en = 1'b0;
    #1;
    total++;
    if ((rd_data_a | rd_data_b | view_data) !== 32'h0) begin
      bad++;
      $display("FAIL z_read got=%h/%h/%h exp=0",
               rd_data_a, rd_data_b, view_data);
    end
    rsv_en = 1'b1; rsv_addr = 5'd0;
    @(posedge clk); #1;
    rsv_en = 1'b0;
    #1;
    total++;
    if (pend_a !== 1'b0) begin
      bad++;
      $display("FAIL z_pend got=%b exp=0", pend_a);
    end
  endtask

  task automatic test_pend();
    @(posedge clk); #1;
    rsv_en = 1'b1; rsv_addr = 5'd7;
    rd_addr_a = 5'd7; rd_addr_b = 5'd6;
    @(posedge clk); #1;
    rsv_en = 1'b0;
    #1;
    total++;
    if (pend_a !== 1'b1) begin
      bad++;
      $display("FAIL pend_set got=%b exp=1", pend_a);
    end
    total++;
    if (pend_b !== 1'b0) begin
      bad++;
      $display("FAIL pend_other got=%b exp=0", pend_b);
    end
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h77;
    #1;
    total++;
    if (pend_a !== 1'b0 || rd_data_a !== 32'h77) begin
      bad++;
      $display("FAIL pend_fwd got=%b/%h exp=0/77", pend_a, rd_data_a);
    end
    @(posedge clk); #1;
    wr_en = 1'b0;
    #1;
    total++;
    if (pend_a !== 1'b0) begin
      bad++;
      $display("FAIL pend_clr got=%b exp=0", pend_a);
    end
    rsv_en = 1'b1; rsv_addr = 5'd7;
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h78;
    @(posedge clk); #1;
    rsv_en = 1'b0; wr_en = 1'b0;
    #1;
    total++;
    if (pend_a !== 1'b1 || rd_data_a !== 32'h78) begin
      bad++;
      $display("FAIL pend_both got=%b/%h exp=1/78", pend_a, rd_data_a);
    end
  endtask

  task automatic test_restart();
    int first;
    @(posedge clk); #1;
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hA5A5A5A5;
    @(posedge clk); #1;
    wr_addr = 5'd9; wr_data = 32'h1111;
    @(posedge clk); #1;
    wr_en = 1'b0;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h5555;
    rsv_en = 1'b1; rsv_addr = 5'd9;
    rd_addr_a = 5'd9;
    for (int n = 1; n <= 10; n++) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (init_busy !== 1'b1) begin
      bad++;
      $display("FAIL mid_busy got=%b exp=1", init_busy);
    end
    #2;
    rst_n = 1'b1;
    first = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (n == 5) begin
        total++;
        if (rd_data_a !== 32'h0 || pend_a !== 1'b0) begin
          bad++;
          $display("FAIL clr_out got=%h/%b exp=0/0", rd_data_a, pend_a);
        end
      end
      if (!init_busy && first == 0) begin
        first = n;
        wr_en = 1'b0;
        rsv_en = 1'b0;
      end
    end
    total++;
    if (first !== 32) begin
      bad++;
      $display("FAIL restart_edges got=%0d exp=32", first);
    end
    view_sel = 5'd3;
    #1;
    total++;
    if (view_data !== 32'h0) begin
      bad++;
      $display("FAIL restart_r3 got=%h exp=0", view_data);
    end
    total++;
    if (rd_data_a !== 32'h0 || pend_a !== 1'b0) begin
      bad++;
      $display("FAIL restart_r9 got=%h/%b exp=0/0", rd_data_a, pend_a);
    end
  endtask

  task automatic test_small();
    int first;
    @(posedge clk); #1;
    s_rst_n = 1'b1;
    first = 0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (!s_init_busy && first == 0) first = n;
    end
    total++;
    if (first !== 8) begin
      bad++;
      $display("FAIL s_edges got=%0d exp=8", first);
    end
    s_wr_en = 1'b1; s_wr_addr = 3'd0; s_wr_data = 16'hABCD;
    s_rd_addr_a = 3'd0; s_view_sel = 3'd0;
    #1;
    total++;
    if (s_rd_data_a !== 16'h0) begin
      bad++;
      $display("FAIL s_nobyp0 got=%h exp=0", s_rd_data_a);
    end
    @(posedge clk); #1;
    s_wr_data = 16'h1234;
    #1;
    total++;
    if (s_rd_data_a !== 16'hABCD) begin
      bad++;
      $display("FAIL s_old got=%h exp=abcd", s_rd_data_a);
    end
    @(posedge clk); #1;
    s_wr_en = 1'b0;
    #1;
    total++;
    if (s_rd_data_a !== 16'h1234 || s_view_data !== 16'h1234) begin
      bad++;
      $display("FAIL s_r0 got=%h/%h exp=1234", s_rd_data_a, s_view_data);
    end
    s_rsv_en = 1'b1; s_rsv_addr = 3'd3;
    @(posedge clk); #1;
    s_rsv_en = 1'b0;
    s_wr_en = 1'b1; s_wr_addr = 3'd3; s_wr_data = 16'h33;
    s_rd_addr_b = 3'd3;
    #1;
    total++;
    if (s_pend_b !== 1'b1 || s_rd_data_b !== 16'h0) begin
      bad++;
      $display("FAIL s_pend_wr got=%b/%h exp=1/0", s_pend_b, s_rd_data_b);
    end
    @(posedge clk); #1;
    s_wr_en = 1'b0;
    #1;
    total++;
    if (s_pend_b !== 1'b0 || s_rd_data_b !== 16'h33) begin
      bad++;
      $display("FAIL s_pend_after got=%b/%h exp=0/33", s_pend_b, s_rd_data_b);
    end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_zero();
    test_pend();
    test_restart();
    test_small();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
